// File: rtl/lsu_pkg.sv
// ============================================================
// lsu_pkg : shared constants, state type and decode helpers
// Rev 1.0
// ============================================================
`default_nettype none

package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic FAULT_MISALIGN = 1'b0;
    localparam logic FAULT_ILLEGAL  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DONE  = 3'd3,
        ST_FAULT = 3'd4
    } lsu_state_t;

    function automatic logic f3_illegal(input logic is_store, input logic [2:0] f3);
        logic bad;
        bad = 1'b1;
        case (f3)
            F3_B, F3_H, F3_W: bad = 1'b0;
            F3_BU, F3_HU:     bad = is_store;
            default:          bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic addr_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
        logic mis;
        mis = 1'b0;
        case (f3)
            F3_H, F3_HU: mis = addr_lo[0];
            F3_W:        mis = (addr_lo != 2'b00);
            default:     mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

`default_nettype wire

// File: rtl/load_store_unit_align.sv
// ============================================================
// lsu_align : combinational store lane steering and load extraction
// Rev 1.0
// ============================================================
`default_nettype none

module lsu_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [1:0]      addr_lo,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] store_data,
    input  logic [XLEN-1:0] rdata,
    output logic [3:0]      wstrb,
    output logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] load_data
);

    logic [XLEN-1:0] w_shifted;

    always_comb begin
        wstrb = 4'b1111;
        wdata = store_data;
        case (funct3)
            F3_B: begin
                wstrb = 4'b0001 << addr_lo;
                wdata = {4{store_data[7:0]}};
            end
            F3_H: begin
                wstrb = 4'b0011 << addr_lo;
                wdata = {2{store_data[15:0]}};
            end
            default: begin
                wstrb = 4'b1111;
                wdata = store_data;
            end
        endcase
    end

    assign w_shifted = rdata >> {addr_lo, 3'b000};

    always_comb begin
        load_data = rdata;
        case (funct3)
            F3_B:    load_data = {{(XLEN-8){w_shifted[7]}}, w_shifted[7:0]};
            F3_H:    load_data = {{(XLEN-16){w_shifted[15]}}, w_shifted[15:0]};
            F3_BU:   load_data = {{(XLEN-8){1'b0}}, w_shifted[7:0]};
            F3_HU:   load_data = {{(XLEN-16){1'b0}}, w_shifted[15:0]};
            default: load_data = rdata;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// ============================================================
// load_store_unit : RV32I execute-to-memory stage with trap detection
// Rev 1.0
// ============================================================
`default_nettype none

module load_store_unit
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_is_store,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    input  logic [4:0]      req_rd,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_addr,
    output logic            mem_we,
    output logic [3:0]      mem_wstrb,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_rsp_valid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            wb_valid,
    output logic            wb_we,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            fault,
    output logic            fault_cause,
    output logic [XLEN-1:0] fault_addr
);

    lsu_state_t      r_state;
    logic            r_is_store;
    logic [2:0]      r_f3;
    logic [XLEN-1:0] r_addr;
    logic [XLEN-1:0] r_wdata;
    logic [4:0]      r_rd;
    logic [XLEN-1:0] r_rdata;
    logic            r_cause;

    logic            w_illegal;
    logic            w_misaligned;
    logic            w_in_req;
    logic            w_in_done;
    logic            w_in_fault;
    logic [3:0]      w_wstrb;
    logic [XLEN-1:0] w_wdata;
    logic [XLEN-1:0] w_load_data;

    assign w_illegal    = f3_illegal(req_is_store, req_funct3);
    assign w_misaligned = addr_misaligned(req_funct3, req_addr[1:0]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_is_store <= 1'b0;
            r_f3       <= 3'b000;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rd       <= 5'd0;
            r_rdata    <= '0;
            r_cause    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_is_store <= req_is_store;
                        r_f3       <= req_funct3;
                        r_addr     <= req_addr;
                        r_wdata    <= req_wdata;
                        r_rd       <= req_rd;
                        r_cause    <= w_illegal ? FAULT_ILLEGAL : FAULT_MISALIGN;
                        r_state    <= (w_illegal || w_misaligned) ? ST_FAULT : ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (mem_req_ready) begin
                        r_state <= ST_WAIT;
                    end
                end
                // Responses are only honoured here; strays elsewhere are dropped.
                ST_WAIT: begin
                    if (mem_rsp_valid) begin
                        r_rdata <= mem_rdata;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE:  r_state <= ST_IDLE;
                ST_FAULT: r_state <= ST_IDLE;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

    lsu_align #(
        .XLEN (XLEN)
    ) u_align (
        .addr_lo    (r_addr[1:0]),
        .funct3     (r_f3),
        .store_data (r_wdata),
        .rdata      (r_rdata),
        .wstrb      (w_wstrb),
        .wdata      (w_wdata),
        .load_data  (w_load_data)
    );

    assign w_in_req   = (r_state == ST_REQ);
    assign w_in_done  = (r_state == ST_DONE);
    assign w_in_fault = (r_state == ST_FAULT);

    assign req_ready     = (r_state == ST_IDLE);
    assign mem_req_valid = w_in_req;
    assign mem_addr      = w_in_req ? {r_addr[XLEN-1:2], 2'b00} : '0;
    assign mem_we        = w_in_req & r_is_store;
    assign mem_wstrb     = (w_in_req && r_is_store) ? w_wstrb : 4'b0000;
    assign mem_wdata     = (w_in_req && r_is_store) ? w_wdata : '0;

    assign wb_valid = w_in_done;
    assign wb_we    = w_in_done & ~r_is_store & (r_rd != 5'd0);
    assign wb_rd    = w_in_done ? r_rd : 5'd0;
    assign wb_data  = (w_in_done && !r_is_store) ? w_load_data : '0;

    assign fault       = w_in_fault;
    assign fault_cause = w_in_fault & r_cause;
    assign fault_addr  = w_in_fault ? r_addr : '0;

endmodule

`default_nettype wire
